// File: rtl/spram_pkg.sv
// Shared constants and types for the SPRAM frame buffer: macro geometry,
// write-lane masks and the arbiter grant encoding.
package spram_pkg;

    localparam int unsigned SPRAM_DEPTH = 16384;
    localparam int unsigned SPRAM_AW    = 14;
    localparam int unsigned SPRAM_DW    = 16;

    localparam logic [3:0] MASK_LANE0 = 4'b0011;
    localparam logic [3:0] MASK_LANE1 = 4'b1100;
    localparam logic [3:0] MASK_FULL  = 4'b1111;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WR   = 2'd1,
        GNT_RD   = 2'd2
    } grant_t;

    function automatic logic [3:0] lane_mask(input logic lane);
        return lane ? MASK_LANE1 : MASK_LANE0;
    endfunction

endpackage

// File: rtl/SB_SPRAM256KA.sv
// Behavioural model of the iCE40UP 16K x 16 single-port RAM primitive.
// Leave this file out of iCE40 synthesis builds; the vendor cell replaces it.
module SB_SPRAM256KA (
    input  logic [13:0] ADDRESS,
    input  logic [15:0] DATAIN,
    input  logic [3:0]  MASKWREN,
    input  logic        WREN,
    input  logic        CHIPSELECT,
    input  logic        CLOCK,
    input  logic        STANDBY,
    input  logic        SLEEP,
    input  logic        POWEROFF,
    output logic [15:0] DATAOUT
);

    logic [15:0] mem_q [16384];
    logic [15:0] dout_q;
    logic        active;

    assign active  = CHIPSELECT & ~STANDBY & ~SLEEP & POWEROFF;
    assign DATAOUT = dout_q;

    // Each MASKWREN bit enables one nibble of the addressed word.
    always_ff @(posedge CLOCK) begin
        if (active) begin
            if (WREN) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (MASKWREN[i]) begin
                        mem_q[ADDRESS][i*4 +: 4] <= DATAIN[i*4 +: 4];
                    end
                end
            end else begin
                dout_q <= mem_q[ADDRESS];
            end
        end
    end

endmodule

// File: rtl/spram_bank.sv
// One SPRAM bank: the SB_SPRAM256KA macro plus optional idle/standby control.
// Define SPRAM_STANDBY_EN to enable the per-bank idle counter and STANDBY.
module spram_bank
    import spram_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cs_i,
    input  logic                we_i,
    input  logic [SPRAM_AW-1:0] addr_i,
    input  logic [15:0]         wdata_i,
    input  logic [3:0]          mask_i,
    input  logic                req_i,
    output logic [15:0]         dout_o,
    output logic                asleep_o
);

    logic standby;

`ifdef SPRAM_STANDBY_EN
    localparam int unsigned CNT_W = $clog2(IDLE_CYCLES + 1);

    logic [CNT_W-1:0] idle_cnt_q;
    logic [CNT_W-1:0] idle_cnt_d;

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (cs_i || req_i) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != CNT_W'(IDLE_CYCLES)) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end

    assign asleep_o = (idle_cnt_q == CNT_W'(IDLE_CYCLES));
    // A pending request drops STANDBY this cycle so the macro is awake by the next edge.
    assign standby  = asleep_o & ~req_i;
`else
    logic unused_pm;
    assign unused_pm = reset_n ^ req_i;
    assign asleep_o  = 1'b0;
    assign standby   = 1'b0;
`endif

    SB_SPRAM256KA u_spram (
        .ADDRESS    (addr_i),
        .DATAIN     (wdata_i),
        .MASKWREN   (mask_i),
        .WREN       (we_i),
        .CHIPSELECT (cs_i),
        .CLOCK      (clk),
        .STANDBY    (standby),
        .SLEEP      (1'b0),
        .POWEROFF   (1'b1),
        .DATAOUT    (dout_o)
    );

endmodule

// File: rtl/spram_frame_buf.sv
// Banked SPRAM frame buffer with a fair single-port arbiter and 2-cycle reads.
// Define SPRAM_STANDBY_EN for per-bank idle standby with a one-cycle wake stall.
module spram_frame_buf
    import spram_pkg::*;
#(
    parameter  int unsigned DATA_W      = 8,
    parameter  int unsigned NUM_BANKS   = 4,
    parameter  int unsigned IDLE_CYCLES = 16,
    localparam int unsigned ADDR_W      = SPRAM_AW + $clog2(NUM_BANKS) + ((DATA_W == 8) ? 1 : 0)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_ready,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_dvalid
);

    localparam int unsigned BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    grant_t              last_q, last_d;
    grant_t              cand, grant;
    logic                stall;
    logic [ADDR_W-1:0]   cand_addr;
    logic [BANK_W-1:0]   cand_bank;
    logic                cand_lane;
    logic [15:0]         wdata16;
    logic [3:0]          wmask;
    logic [NUM_BANKS-1:0] bank_asleep;
    logic [15:0]         bank_dout [NUM_BANKS];

    logic                s1_valid_q, s1_valid_d;
    logic [BANK_W-1:0]   s1_bank_q, s1_bank_d;
    logic                s1_lane_q, s1_lane_d;
    logic [15:0]         s1_word;
    logic [DATA_W-1:0]   s1_data;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_dvalid_q, rd_dvalid_d;

    // Contention alternates on the last granted type; reset leaves "read" so write goes first.
    always_comb begin
        cand = GNT_NONE;
        if (wr_valid && rd_valid) begin
            cand = (last_q == GNT_WR) ? GNT_RD : GNT_WR;
        end else if (wr_valid) begin
            cand = GNT_WR;
        end else if (rd_valid) begin
            cand = GNT_RD;
        end
    end

    assign cand_addr = (cand == GNT_RD) ? rd_addr : wr_addr;
    assign stall     = (cand != GNT_NONE) && bank_asleep[cand_bank];
    assign grant     = stall ? GNT_NONE : cand;
    assign wr_ready  = (grant == GNT_WR);
    assign rd_ready  = (grant == GNT_RD);
    assign last_d    = (grant != GNT_NONE) ? grant : last_q;

    if (NUM_BANKS > 1) begin : g_bank_sel
        assign cand_bank = cand_addr[SPRAM_AW +: BANK_W];
    end else begin : g_bank_one
        assign cand_bank = '0;
    end

    if (DATA_W == 8) begin : g_byte
        assign cand_lane = cand_addr[ADDR_W-1];
        assign wdata16   = {wr_data, wr_data};
        assign wmask     = lane_mask(cand_lane);
        assign s1_data   = s1_lane_q ? s1_word[15:8] : s1_word[7:0];
    end else begin : g_word
        assign cand_lane = 1'b0;
        assign wdata16   = wr_data;
        assign wmask     = MASK_FULL;
        assign s1_data   = s1_word;
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic sel;
        assign sel = (cand_bank == BANK_W'(b));

        spram_bank #(
            .IDLE_CYCLES (IDLE_CYCLES)
        ) u_bank (
            .clk      (clk),
            .reset_n  (reset_n),
            .cs_i     (sel && (grant != GNT_NONE)),
            .we_i     (sel && (grant == GNT_WR)),
            .addr_i   (cand_addr[SPRAM_AW-1:0]),
            .wdata_i  (wdata16),
            .mask_i   (wmask),
            .req_i    (sel && (cand != GNT_NONE)),
            .dout_o   (bank_dout[b]),
            .asleep_o (bank_asleep[b])
        );
    end

    assign s1_word = bank_dout[s1_bank_q];

    // Bank and lane travel with the read so the registered output picks the right macro.
    always_comb begin
        s1_valid_d  = rd_ready;
        s1_bank_d   = cand_bank;
        s1_lane_d   = cand_lane;
        rd_dvalid_d = s1_valid_q;
        rd_data_d   = rd_data_q;
        if (s1_valid_q) begin
            rd_data_d = s1_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q      <= GNT_RD;
            s1_valid_q  <= 1'b0;
            s1_bank_q   <= '0;
            s1_lane_q   <= 1'b0;
            rd_dvalid_q <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            last_q      <= last_d;
            s1_valid_q  <= s1_valid_d;
            s1_bank_q   <= s1_bank_d;
            s1_lane_q   <= s1_lane_d;
            rd_dvalid_q <= rd_dvalid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_dvalid = rd_dvalid_q;

endmodule

// File: tb/tb_spram_frame_buf.sv
// Self-checking bench for spram_frame_buf (8-bit/4-bank and 16-bit/2-bank builds).
// The standby scenario is exercised only when SPRAM_STANDBY_EN is defined.
module tb_spram_frame_buf;

    localparam int IDLE = 16;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b1;

    logic        wr_valid = 1'b0, rd_valid = 1'b0;
    logic        wr_ready, rd_ready, rd_dvalid;
    logic [16:0] wr_addr = '0, rd_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [7:0]  rd_data;

    logic        w16_valid = 1'b0, r16_valid = 1'b0;
    logic        w16_ready, r16_ready, r16_dvalid;
    logic [14:0] w16_addr = '0, r16_addr = '0;
    logic [15:0] w16_data = '0;
    logic [15:0] r16_data;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    spram_frame_buf #(.DATA_W(8), .NUM_BANKS(4), .IDLE_CYCLES(IDLE)) dut8 (
        .clk(clk), .reset_n(reset_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_dvalid(rd_dvalid)
    );

    spram_frame_buf #(.DATA_W(16), .NUM_BANKS(2), .IDLE_CYCLES(IDLE)) dut16 (
        .clk(clk), .reset_n(reset_n),
        .wr_valid(w16_valid), .wr_ready(w16_ready), .wr_addr(w16_addr), .wr_data(w16_data),
        .rd_valid(r16_valid), .rd_ready(r16_ready), .rd_addr(r16_addr),
        .rd_data(r16_data), .rd_dvalid(r16_dvalid)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: byte memory keyed by full address, queue of pending reads.
    typedef struct { int due; logic [7:0] data; } pend_t;
    typedef struct { int cyc; logic [7:0] data; } log_t;
    logic [7:0] mmem [int];
    pend_t      pq[$];
    log_t       rd_log[$];
    bit         last_wr = 1'b0;
    logic [7:0] exp_data = '0;
    int         idle_cnt [4];

    always @(negedge clk) begin : model
        bit exp_dv, exp_w, exp_r, stall;
        if (!reset_n) begin
            pq.delete();
            last_wr  = 1'b0;
            exp_data = '0;
            foreach (idle_cnt[i]) idle_cnt[i] = 0;
            chk("reset rd_dvalid", 16'(rd_dvalid), 16'h0);
            chk("reset rd_data", 16'(rd_data), 16'h0);
        end else begin
            exp_dv = (pq.size() > 0) && (pq[0].due == cyc);
            if (exp_dv) begin
                exp_data = pq[0].data;
                void'(pq.pop_front());
            end
            chk("rd_dvalid", 16'(rd_dvalid), 16'(exp_dv));
            chk("rd_data", 16'(rd_data), 16'(exp_data));
            if (rd_dvalid) rd_log.push_back('{cyc, rd_data});

            exp_w = wr_valid && (!rd_valid || !last_wr);
            exp_r = rd_valid && !exp_w;
            stall = 1'b0;
`ifdef SPRAM_STANDBY_EN
            begin
                int bank;
                bank  = ((exp_w ? int'(wr_addr) : int'(rd_addr)) / 16384) % 4;
                stall = (exp_w || exp_r) && (idle_cnt[bank] >= IDLE);
                for (int i = 0; i < 4; i++) begin
                    if (i == bank && (exp_w || exp_r)) idle_cnt[i] = 0;
                    else if (idle_cnt[i] < IDLE)      idle_cnt[i] = idle_cnt[i] + 1;
                end
            end
`endif
            if (stall) begin
                exp_w = 1'b0;
                exp_r = 1'b0;
            end
            chk("wr_ready", 16'(wr_ready), 16'(exp_w));
            chk("rd_ready", 16'(rd_ready), 16'(exp_r));
            if (exp_w) begin
                mmem[int'(wr_addr)] = wr_data;
                last_wr = 1'b1;
            end
            if (exp_r) begin
                pq.push_back('{cyc + 2, mmem.exists(int'(rd_addr)) ? mmem[int'(rd_addr)] : 8'h00});
                last_wr = 1'b0;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_acc(input bit is_wr, input string name, output int acc);
        bit got = 1'b0;
        acc = -100;
        for (int n = 0; n < 8 && !got; n++) begin
            @(negedge clk);
            got = is_wr ? wr_ready : rd_ready;
            if (got) acc = cyc;
            @(posedge clk);
            #1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s: ready got 0 expected 1 within 8 cycles", name);
        end
    endtask

    task automatic wr8(input logic [16:0] a, input logic [7:0] d);
        int acc;
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        wait_acc(1'b1, "wr8 handshake", acc);
        wr_valid = 1'b0;
    endtask

    task automatic rd8(input logic [16:0] a, output int acc);
        rd_valid = 1'b1; rd_addr = a;
        wait_acc(1'b0, "rd8 handshake", acc);
        rd_valid = 1'b0;
    endtask

    task automatic expect_rd(input int acc, input logic [7:0] exp, input string name);
        int hit = -1;
        foreach (rd_log[i]) if (rd_log[i].cyc == acc + 2) hit = i;
        checks++;
        if (hit < 0) begin
            errors++;
            $display("FAIL %s: no rd_dvalid at cycle %0d, expected data %h", name, acc + 2, exp);
        end else if (rd_log[hit].data !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, rd_log[hit].data, exp);
        end
    endtask

    task automatic w16(input logic [14:0] a, input logic [15:0] d);
        bit got = 1'b0;
        w16_valid = 1'b1; w16_addr = a; w16_data = d;
        for (int n = 0; n < 8 && !got; n++) begin
            @(negedge clk);
            got = w16_ready;
            @(posedge clk);
            #1;
        end
        w16_valid = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL w16 handshake: ready got 0 expected 1");
        end
    endtask

    task automatic r16(input logic [14:0] a, input logic [15:0] exp, input string name);
        bit got = 1'b0;
        r16_valid = 1'b1; r16_addr = a;
        for (int n = 0; n < 8 && !got; n++) begin
            @(negedge clk);
            got = r16_ready;
            @(posedge clk);
            #1;
        end
        r16_valid = 1'b0;
        if (!got) begin
            checks++; errors++;
            $display("FAIL %s handshake: ready got 0 expected 1", name);
        end
        @(negedge clk);
        chk({name, " dvalid N+1"}, 16'(r16_dvalid), 16'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk({name, " dvalid N+2"}, 16'(r16_dvalid), 16'h1);
        chk({name, " data"}, r16_data, exp);
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin : stim
        int a0, a1, a2, nlate;
        logic [15:0] seq;
        int ng;

        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("post-reset rd_data", 16'(rd_data), 16'h0);
        chk("post-reset rd_dvalid", 16'(rd_dvalid), 16'h0);
        chk("post-reset r16_data", r16_data, 16'h0);
        @(posedge clk); #1;

        // Byte lanes of the same word
        wr8(17'h00000, 8'hA5);
        wr8(17'h10000, 8'h5A);
        rd8(17'h00000, a0);
        rd8(17'h10000, a1);
        idle(3);
        expect_rd(a0, 8'hA5, "lane0 read");
        expect_rd(a1, 8'h5A, "lane1 read");
        chk("lane reads back-to-back", 16'(a1 - a0), 16'h1);

        // Read immediately after write, and lane isolation
        wr8(17'h00123, 8'h3C);
        rd8(17'h00123, a0);
        wr8(17'h10000, 8'hC3);
        rd8(17'h10000, a1);
        rd8(17'h00000, a2);
        idle(3);
        expect_rd(a0, 8'h3C, "raw new data");
        expect_rd(a1, 8'hC3, "raw lane1");
        expect_rd(a2, 8'hA5, "lane0 untouched");

        // Back-to-back reads across banks 1..3
        wr8(17'h04000, 8'h11);
        wr8(17'h08000, 8'h22);
        wr8(17'h0C000, 8'h33);
        rd8(17'h04000, a0);
        rd8(17'h08000, a1);
        rd8(17'h0C000, a2);
        idle(3);
        expect_rd(a0, 8'h11, "bank1 read");
        expect_rd(a1, 8'h22, "bank2 read");
        expect_rd(a2, 8'h33, "bank3 read");
        chk("bank reads consecutive", 16'(a2 - a0), 16'h2);

        // Reset one cycle after read acceptance drops the result
        rd8(17'h04000, a0);
        reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        idle(4);
        nlate = 0;
        foreach (rd_log[i]) if (rd_log[i].cyc > a0) nlate++;
        chk("reset drops in-flight read", 16'(nlate), 16'h0);
        @(negedge clk);
        chk("rd_data after reset", 16'(rd_data), 16'h00);
        @(posedge clk); #1;

        // Contention after reset: write first, then alternate
        wr_valid = 1'b1; wr_addr = 17'h00200; wr_data = 8'h99;
        rd_valid = 1'b1; rd_addr = 17'h00000;
        seq = '0;
        ng  = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (ng < 4 && wr_ready)      begin seq = {seq[11:0], 4'h1}; ng++; end
            else if (ng < 4 && rd_ready) begin seq = {seq[11:0], 4'h2}; ng++; end
            @(posedge clk); #1;
        end
        wr_valid = 1'b0; rd_valid = 1'b0;
        chk("grant order W,R,W,R", seq, 16'h1212);
        rd8(17'h00200, a0);
        idle(3);
        expect_rd(a0, 8'h99, "contended write data");

`ifdef SPRAM_STANDBY_EN
        // Idle long enough for bank 0 to sleep, then read it
        idle(20);
        @(negedge clk);
        chk("bank0 STANDBY after idle", 16'(dut8.g_bank[0].u_bank.standby), 16'h1);
        @(posedge clk); #1;
        rd_valid = 1'b1; rd_addr = 17'h00000;
        @(negedge clk);
        chk("wake cycle rd_ready", 16'(rd_ready), 16'h0);
        chk("wake cycle STANDBY", 16'(dut8.g_bank[0].u_bank.standby), 16'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post-wake rd_ready", 16'(rd_ready), 16'h1);
        a0 = cyc;
        @(posedge clk); #1;
        rd_valid = 1'b0;
        idle(3);
        expect_rd(a0, 8'hA5, "read after wake");
`endif

        // 16-bit, 2-bank build: full-word mask
        w16(15'h7FFF, 16'hFFFF);
        w16(15'h7FFF, 16'h1234);
        w16(15'h0000, 16'hBEEF);
        r16(15'h7FFF, 16'h1234, "w16 top word");
        r16(15'h0000, 16'hBEEF, "w16 bank0 word");

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
